// File: rtl/wvb_rd_pkg.sv
// Shared types and constants for the waveform buffer read engine.
package wvb_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Header field offsets, counted in whole address-width fields.
  localparam int HDR_START_LSB = 0;
  localparam int HDR_STOP_LSB  = 1;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/wvb_rd_skid_fifo.sv
// Two-entry registered FIFO that holds waveform words with their sof/last tags.
module wvb_rd_skid_fifo
  import wvb_rd_pkg::*;
#(
  parameter int P_WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [P_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [P_WIDTH-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [P_WIDTH-1:0] mem [SKID_DEPTH];
  logic               wr_idx;
  logic               rd_idx;
  logic [1:0]         cnt;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (cnt == 2'(SKID_DEPTH));
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;
  assign head    = mem[rd_idx];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop_ok) rd_idx <= ~rd_idx;
      cnt <= cnt + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/waveform_buffer_reader.sv
// Pops a header and streams waveform RAM words start..stop (circular) on valid/ready.
// Optional WVB_RD_EOE_CHECK_EN adds a sticky eoe-bit vs dout_last mismatch flag.
//
// state | meaning
// IDLE  | wait for a header, pop it
// LATCH | wait out FIFO read latency, capture header, load rd_ptr
// READ  | issue RAM reads while the skid FIFO has credit
// DRAIN | stop issued, wait for last beat acceptance
module waveform_buffer_reader
  import wvb_rd_pkg::*;
#(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data_in,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_in,
  output logic [P_HDR_WIDTH-1:0]  hdr_out,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_sof,
  output logic                    dout_last,
  output logic                    rd_done,
  output logic [P_ADR_WIDTH-1:0]  wvb_free_ptr,
  output logic                    eoe_err
);

  localparam int SKID_W = P_DATA_WIDTH + 2;

  state_t                   state;
  logic [P_ADR_WIDTH-1:0]   rd_ptr;
  logic [P_ADR_WIDTH-1:0]   stop_addr;
  logic                     first_pend;
  logic                     inflight;
  logic                     inflight_sof;
  logic                     inflight_last;
  logic [SKID_W-1:0]        skid_head;
  logic                     skid_full;
  logic                     skid_empty;
  logic [1:0]               skid_count;
  logic                     pop;
  logic [2:0]               occupancy;
  logic                     rd_issue;
  logic                     drain_done;

  assign stop_addr   = hdr_out[HDR_STOP_LSB*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign wvb_rd_addr = rd_ptr;

  assign dout_valid = !skid_empty;
  assign {dout_sof, dout_last, dout} = skid_head;
  assign pop        = dout_valid && dout_ready;

  // Words already committed to the skid after this cycle's pop; a new read
  // is only issued if its word is guaranteed a slot when it lands.
  assign occupancy  = 3'(skid_count) + 3'(inflight) - 3'(pop);
  assign rd_issue   = (state == READ) && (occupancy < 3'(SKID_DEPTH));
  assign drain_done = (state == DRAIN) && pop && dout_last;

  wvb_rd_skid_fifo #(.P_WIDTH(SKID_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_sof, inflight_last, wvb_data_in}),
    .pop       (pop),
    .head      (skid_head),
    .full      (skid_full),
    .empty     (skid_empty),
    .count     (skid_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hdr_rdreq     <= 1'b0;
      hdr_out       <= '0;
      rd_ptr        <= '0;
      first_pend    <= 1'b0;
      inflight      <= 1'b0;
      inflight_sof  <= 1'b0;
      inflight_last <= 1'b0;
      rd_done       <= 1'b0;
      wvb_free_ptr  <= '0;
    end else begin
      rd_done  <= 1'b0;
      inflight <= rd_issue;
      if (rd_issue) begin
        inflight_sof  <= first_pend;
        inflight_last <= (rd_ptr == stop_addr);
        first_pend    <= 1'b0;
        rd_ptr        <= rd_ptr + P_ADR_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (!hdr_empty) begin
            hdr_rdreq <= 1'b1;
            state     <= LATCH;
          end
        end
        LATCH: begin
          // First LATCH cycle is the pop itself; header data is valid the next.
          if (hdr_rdreq) begin
            hdr_rdreq <= 1'b0;
          end else begin
            hdr_out    <= hdr_data_in;
            rd_ptr     <= hdr_data_in[HDR_START_LSB*P_ADR_WIDTH +: P_ADR_WIDTH];
            first_pend <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          if (rd_issue && (rd_ptr == stop_addr)) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            rd_done      <= 1'b1;
            wvb_free_ptr <= stop_addr + P_ADR_WIDTH'(1);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WVB_RD_EOE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eoe_err <= 1'b0;
    end else if (pop && (dout[0] != dout_last)) begin
      eoe_err <= 1'b1;
    end
  end
`else
  assign eoe_err = 1'b0;
`endif

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Scoreboard bench for waveform_buffer_reader: header FIFO and RAM models drive the
// DUT; expected beats are derived from header ranges and checked by a monitor.
module tb_waveform_buffer_reader;

  localparam int D = 22;
  localparam int A = 12;
  localparam int H = 80;

  typedef struct {
    logic [D-1:0] data;
    logic         sof;
    logic         last;
    logic [H-1:0] hdr;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         hdr_empty;
  logic [H-1:0] hdr_data_in;
  logic         hdr_rdreq;
  logic [A-1:0] wvb_rd_addr;
  logic [D-1:0] wvb_data_in;
  logic [H-1:0] hdr_out;
  logic [D-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_sof;
  logic         dout_last;
  logic         rd_done;
  logic [A-1:0] wvb_free_ptr;
  logic         eoe_err;

  waveform_buffer_reader #(
    .P_DATA_WIDTH(D), .P_ADR_WIDTH(A), .P_HDR_WIDTH(H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_empty    (hdr_empty),
    .hdr_data_in  (hdr_data_in),
    .hdr_rdreq    (hdr_rdreq),
    .wvb_rd_addr  (wvb_rd_addr),
    .wvb_data_in  (wvb_data_in),
    .hdr_out      (hdr_out),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_sof     (dout_sof),
    .dout_last    (dout_last),
    .rd_done      (rd_done),
    .wvb_free_ptr (wvb_free_ptr),
    .eoe_err      (eoe_err)
  );

  logic [D-1:0] ram [1 << A];
  logic [H-1:0] hq [$];
  beat_t        exp_q [$];
  logic [A-1:0] free_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int dones = 0;
  int ready_mode = 0;
  int pidx = 0;

  bit           prev_stall = 0;
  logic [D-1:0] prev_dout;
  logic [1:0]   prev_flags;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) cyc++;

  // RAM and header FIFO models, both with one cycle of read latency.
  always @(posedge clk) wvb_data_in <= ram[wvb_rd_addr];
  always @(posedge clk) if (rst_n && hdr_rdreq) hdr_data_in <= (hq.size() != 0) ? hq.pop_front() : '0;
  always @(negedge clk) hdr_empty = (hq.size() == 0);

  initial begin
    dout_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: dout_ready = 1;
        1: dout_ready = ($urandom_range(0, 3) != 0);
        default: begin
          dout_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
          pidx++;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [H-1:0] act, input logic [H-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: beats, rd_done/free pointer, stall stability, header pop ordering.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1'b1);
        check("stall_stable", {dout_sof, dout_last, dout}, {prev_flags, prev_dout});
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", dout, '1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", dout, e.data);
          check("beat_flags", {dout_sof, dout_last}, {e.sof, e.last});
          check("beat_hdr", hdr_out, e.hdr);
        end
      end
      if (rd_done) begin
        dones++;
        if (free_q.size() == 0) check("extra_done", 1'b1, 1'b0);
        else check("free_ptr", wvb_free_ptr, free_q.pop_front());
      end
      if (hdr_rdreq) begin
        check("rdreq_nonempty", hq.size() != 0, 1'b1);
        check("rdreq_after_done", pops, dones);
        pops++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_flags = {dout_sof, dout_last};
    end
  end

  task automatic add_wave(input logic [A-1:0] start, input logic [A-1:0] stop, input logic [H-2*A-1:0] meta);
    logic [A-1:0] span;
    logic [A-1:0] addr;
    logic [H-1:0] hdr;
    int len;
    beat_t b;
    hdr  = {meta, stop, start};
    span = stop - start;
    len  = int'(span) + 1;
    for (int i = 0; i < len; i++) begin
      addr   = start + A'(i);
      b.data = ram[addr];
      b.sof  = (i == 0);
      b.last = (i == len - 1);
      b.hdr  = hdr;
      exp_q.push_back(b);
    end
    free_q.push_back(stop + A'(1));
    hq.push_back(hdr);
  endtask

  task automatic wait_for(input int which, input int limit, input string name, output int t);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = hdr_rdreq;
        1: hit = dout_valid;
        default: hit = rd_done;
      endcase
    end
    t = cyc;
    check(name, hit, 1'b1);
  endtask

  initial begin
    int t0, t1, tmp, n;
    logic [A-1:0] s;
    rst_n       = 0;
    hdr_empty   = 1;
    hdr_data_in = '0;
    wvb_data_in = '0;
    for (int i = 0; i < (1 << A); i++) ram[i] = D'(i);
    repeat (3) @(negedge clk);
    check("reset_outputs", {hdr_rdreq, dout_valid, rd_done, dout_sof, dout_last, dout, wvb_free_ptr}, '0);
    check("reset_hdr_out", hdr_out, '0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Basic waveform with latency checks.
    add_wave(12'h010, 12'h013, 56'hA5);
    wait_for(0, 20, "t1_rdreq", t0);
    wait_for(1, 20, "t1_valid", t1);
    check("t1_first_valid_lat", t1 - t0, 4);
    wait_for(2, 20, "t1_done", t1);
    check("t1_done_lat", t1 - t0, 8);
    check("t1_free_ptr", wvb_free_ptr, 12'h014);

    // Wrapped waveform.
    add_wave(12'hFFE, 12'h001, 56'h1234);
    wait_for(2, 40, "wrap_done", tmp);
    check("wrap_free_ptr", wvb_free_ptr, 12'h002);

    // Single sample.
    add_wave(12'h123, 12'h123, 56'h77);
    wait_for(2, 40, "single_done", tmp);
    check("single_drained", exp_q.size(), 0);

    // Backpressure 1,0,0,1.
    ready_mode = 2;
    add_wave(12'h200, 12'h205, 56'hBEEF);
    wait_for(2, 80, "bp_done", tmp);
    check("bp_drained", exp_q.size(), 0);

    // Randomized headers, data and backpressure.
    ready_mode = 1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < (1 << A); i++) ram[i] = D'($urandom);
    for (int k = 0; k < 24; k++) begin
      s = A'($urandom);
      add_wave(s, s + A'($urandom_range(0, 11)), {$urandom, 24'($urandom)});
    end
    n = 0;
    while ((free_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("random_drained", {free_q.size(), exp_q.size()}, '0);

    // Two queued headers, reset in the middle of the second.
    ready_mode = 0;
    repeat (3) @(negedge clk);
    add_wave(12'h300, 12'h303, 56'h1);
    add_wave(12'h400, 12'h407, 56'h2);
    wait_for(2, 40, "q1_done", tmp);
    wait_for(1, 20, "q2_valid", tmp);
    repeat (2) @(negedge clk);
    check("q2_streaming", dout_valid, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("midreset_outputs", {hdr_rdreq, dout_valid, rd_done, dout_sof, dout_last, dout, wvb_free_ptr}, '0);
    check("midreset_hdr_out", hdr_out, '0);
    exp_q.delete();
    free_q.delete();
    hq.delete();
    pops  = 0;
    dones = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    repeat (10) @(negedge clk);
    check("no_done_after_reset", {dones, pops}, '0);
    check("idle_after_reset", dout_valid, 1'b0);

`ifdef WVB_RD_EOE_CHECK_EN
    for (int a = 16'h500; a <= 16'h503; a++) ram[a] = ram[a] & ~D'(1);
    check("eoe_clear", eoe_err, 1'b0);
    add_wave(12'h500, 12'h503, 56'h3);
    wait_for(2, 40, "eoe_done", tmp);
    check("eoe_set", eoe_err, 1'b1);
    repeat (5) @(negedge clk);
    check("eoe_sticky", eoe_err, 1'b1);
`else
    add_wave(12'h500, 12'h503, 56'h3);
    wait_for(2, 40, "eoe_off_done", tmp);
    check("eoe_tied", eoe_err, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
